// File: rtl/axi_llc_data_line_seq.sv
// Line-level sequencer in front of the single-port LLC data SRAM.
// A line request is split into BeatsPerLine word accesses. Read data is
// tracked through the SRAM latency and lands in a response FIFO. Reads are
// only issued while the FIFO has room for them, so backpressure never drops data.
//
// state | meaning
// IDLE  | waiting for a line request (req_ready_o=1)
// WRITE | one SRAM write per accepted write beat
// READ  | one SRAM read per cycle while response credit is available
module axi_llc_data_line_seq #(
  parameter  int NumWords     = 1024,
  parameter  int DataWidth    = 128,
  parameter  int ByteWidth    = 8,
  parameter  int Latency      = 1,
  parameter  int BeatsPerLine = 4,
  parameter  int RspDepth     = 2,
  localparam int AddrWidth    = $clog2(NumWords),
  localparam int BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int BeatW        = $clog2(BeatsPerLine),
  localparam int LineW        = AddrWidth - BeatW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [LineW-1:0]     req_line_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   wbe_i,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rdata_last_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 busy_o
);

  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CntW = $clog2(RspDepth + 1);
  localparam int InfW = $clog2(Latency + 1);
  localparam int OccW = $clog2(RspDepth + Latency + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e             state_q, state_d;
  logic [LineW-1:0]   line_q;
  logic [BeatW-1:0]   beat_q;
  logic               beat_last;
  logic               req_ready, wdata_ready, accept, wr_issue, rd_issue;

  logic [Latency-1:0] pipe_valid, pipe_last;
  logic [InfW-1:0]    inflight;
  logic [OccW-1:0]    occupancy;
  logic               credit_ok;

  logic [DataWidth-1:0] fifo_data [RspDepth];
  logic [RspDepth-1:0]  fifo_last;
  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      fifo_cnt;
  logic                 fifo_nonempty, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign beat_last = (beat_q == BeatW'(BeatsPerLine - 1));

  // Reads in flight plus beats already buffered; a read is only issued when
  // its beat is guaranteed a FIFO slot. A pop frees credit on the next cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < Latency; i++) inflight = inflight + InfW'(pipe_valid[i]);
  end

  assign occupancy = OccW'(fifo_cnt) + OccW'(inflight);
  assign credit_ok = occupancy < OccW'(RspDepth);

  // Next-state and per-cycle issue decisions.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    accept      = 1'b0;
    wr_issue    = 1'b0;
    rd_issue    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = req_we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        if (wdata_valid_i) begin
          wr_issue = 1'b1;
          if (beat_last) state_d = IDLE;
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          if (beat_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched line index and beat counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        line_q <= req_line_i;
        beat_q <= '0;
      end else if (wr_issue || rd_issue) begin
        beat_q <= beat_q + BeatW'(1);
      end
    end
  end

  // Shift register tracking each read (and its last flag) through the SRAM latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid[0] <= rd_issue;
      pipe_last[0]  <= rd_issue & beat_last;
      for (int i = 1; i < Latency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  assign push          = pipe_valid[Latency-1];
  assign fifo_nonempty = (fifo_cnt != '0);
  assign pop           = fifo_nonempty & rdata_ready_i;

  // Response FIFO; storage is left unreset since only valid entries are visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= sram_rdata_i;
        fifo_last[wr_ptr] <= pipe_last[Latency-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CntW'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CntW'(1);
    end
  end

  // Every output is forced low while reset is held.
  assign req_ready_o   = req_ready & ~rst_i;
  assign wdata_ready_o = wdata_ready & ~rst_i;
  assign sram_req_o    = (wr_issue | rd_issue) & ~rst_i;
  assign sram_we_o     = wr_issue & ~rst_i;
  assign sram_addr_o   = rst_i ? '0 : {line_q, beat_q};
  assign sram_wdata_o  = rst_i ? '0 : wdata_i;
  assign sram_be_o     = (wr_issue && !rst_i) ? wbe_i : '0;
  assign rdata_valid_o = fifo_nonempty & ~rst_i;
  assign rdata_o       = rdata_valid_o ? fifo_data[rd_ptr] : '0;
  assign rdata_last_o  = rdata_valid_o & fifo_last[rd_ptr];
  assign busy_o        = ~rst_i & ((state_q != IDLE) | (inflight != '0) | fifo_nonempty);

endmodule

// File: tb/tb_axi_llc_data_line_seq.sv
// Bench for axi_llc_data_line_seq: three instances (Latency 1/2/3) share the
// stimulus buses; each has its own request valid and behavioural SRAM.
module tb_axi_llc_data_line_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_valid;
  logic        req_we;
  logic [7:0]  req_line;
  logic        wdata_valid;
  logic [127:0] wdata;
  logic [15:0] wbe;
  logic        rdata_ready;

  logic [2:0] req_ready, wdata_ready, rdata_valid, rdata_last, sram_req, sram_we, busy;
  logic [2:0][127:0] rdata, sram_wdata, sram_rdata;
  logic [2:0][9:0]   sram_addr;
  logic [2:0][15:0]  sram_be;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt[3] = '{0, 0, 0};
  logic [128:0] rq0[$], rq1[$], rq2[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int Lat = g + 1;
    localparam int Dep = (g == 2) ? 4 : 2;
    logic [127:0] mem [1024];
    logic [127:0] pipe [Lat];

    axi_llc_data_line_seq #(.Latency(Lat), .RspDepth(Dep)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
      .req_we_i(req_we), .req_line_i(req_line),
      .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready[g]),
      .wdata_i(wdata), .wbe_i(wbe),
      .rdata_valid_o(rdata_valid[g]), .rdata_ready_i(rdata_ready),
      .rdata_o(rdata[g]), .rdata_last_o(rdata_last[g]),
      .sram_req_o(sram_req[g]), .sram_we_o(sram_we[g]), .sram_addr_o(sram_addr[g]),
      .sram_wdata_o(sram_wdata[g]), .sram_be_o(sram_be[g]), .sram_rdata_i(sram_rdata[g]),
      .busy_o(busy[g])
    );

    always @(posedge clk) begin
      if (sram_req[g]) begin
        if (sram_we[g])
          for (int b = 0; b < 16; b++)
            if (sram_be[g][b]) mem[sram_addr[g]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
        pipe[0] <= mem[sram_addr[g]];
      end
      for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_rdata[g] = pipe[Lat-1];
  end

  // Log read-beat handshakes and SRAM read issues, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdata_valid[0] && rdata_ready) rq0.push_back({rdata_last[0], rdata[0]});
      if (rdata_valid[1] && rdata_ready) rq1.push_back({rdata_last[1], rdata[1]});
      if (rdata_valid[2] && rdata_ready) rq2.push_back({rdata_last[2], rdata[2]});
      for (int s = 0; s < 3; s++) if (sram_req[s] && !sram_we[s]) rd_cnt[s]++;
    end
  end

  function automatic int qsize(input int s);
    case (s)
      0: return rq0.size();
      1: return rq1.size();
      default: return rq2.size();
    endcase
  endfunction

  function automatic logic [128:0] qget(input int s, input int i);
    case (s)
      0: return rq0[i];
      1: return rq1[i];
      default: return rq2[i];
    endcase
  endfunction

  // Entered and left at the drive point (1 time unit after a rising edge).
  task automatic send_req(input int s, input logic we, input logic [7:0] line);
    bit ok = 0;
    req_valid = '0; req_valid[s] = 1'b1; req_we = we; req_line = line;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (req_ready[s]) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_accept sel=%0d: req_ready stayed 0, required 1", s);
    end
  endtask

  task automatic send_beats(input logic [3:0][127:0] d, input logic [3:0][15:0] be);
    for (int b = 0; b < 4; b++) begin
      wdata_valid = 1'b1; wdata = d[b]; wbe = be[b];
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_beats(input int s, input int n, input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (qsize(s) >= base + n) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL beats_timeout sel=%0d: got %0d beats, required %0d", s, qsize(s) - base, n);
    end
  endtask

  task automatic wait_idle(input int s);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (busy[s] === 1'b0) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL busy_fall sel=%0d: busy=%b, required 0", s, busy[s]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; wdata = '1; wbe = '1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({req_ready[s], wdata_ready[s], rdata_valid[s], rdata_last[s], sram_req[s], sram_we[s], busy[s]} !== 7'b0 ||
          sram_addr[s] !== 10'd0 || sram_be[s] !== 16'd0 || sram_wdata[s] !== 128'd0 || rdata[s] !== 128'd0) begin
        bad++;
        $display("FAIL reset_outputs sel=%0d: ctl=%b addr=%h be=%h wd=%h, required all 0", s,
                 {req_ready[s], wdata_ready[s], rdata_valid[s], rdata_last[s], sram_req[s], sram_we[s], busy[s]},
                 sram_addr[s], sram_be[s], sram_wdata[s]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; wbe = '0;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 3'b111 || busy !== 3'b000) begin
      bad++; $display("FAIL reset_release: req_ready=%b busy=%b, required 111 000", req_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int base;
    bit ok;
    send_req(0, 1'b1, 8'd3);
    for (int b = 0; b < 4; b++) begin
      wdata_valid = 1'b1; wdata = 128'hA0 + 128'(b); wbe = '1;
      @(negedge clk); #1;
      total++;
      if (sram_req[0] !== 1'b1 || sram_we[0] !== 1'b1 || sram_addr[0] !== 10'(12 + b) ||
          sram_wdata[0] !== 128'hA0 + 128'(b) || sram_be[0] !== 16'hFFFF) begin
        bad++;
        $display("FAIL wr_beat%0d: req=%b we=%b addr=%0d wd=%h be=%h, required 1 1 %0d %h ffff",
                 b, sram_req[0], sram_we[0], sram_addr[0], sram_wdata[0], sram_be[0], 12 + b, 128'hA0 + 128'(b));
      end
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready[0] !== 1'b1 || sram_req[0] !== 1'b0) begin
      bad++; $display("FAIL wr_to_idle: req_ready=%b sram_req=%b, required 1 0", req_ready[0], sram_req[0]);
    end
    @(posedge clk); #1;
    rdata_ready = 1'b1;
    base = rq0.size();
    send_req(0, 1'b0, 8'd3);
    wait_beats(0, 4, base, ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (qget(0, base + i) !== {(i == 3), 128'hA0 + 128'(i)}) begin
          bad++;
          $display("FAIL rd_beat%0d: got %h, required %h", i, qget(0, base + i), {(i == 3), 128'hA0 + 128'(i)});
        end
      end
    end
    @(posedge clk); #1;
    wait_idle(0);
  endtask

  task automatic test_backpressure;
    int base, cnt0;
    bit ok;
    rdata_ready = 1'b0;
    base = rq0.size();
    cnt0 = rd_cnt[0];
    send_req(0, 1'b0, 8'd3);
    repeat (8) @(negedge clk);
    #1;
    total++;
    if (rd_cnt[0] - cnt0 !== 2 || sram_req[0] !== 1'b0 || rdata_valid[0] !== 1'b1 || rdata[0] !== 128'hA0) begin
      bad++;
      $display("FAIL bp_stall: reads=%0d sram_req=%b rvalid=%b rdata=%h, required 2 0 1 a0",
               rd_cnt[0] - cnt0, sram_req[0], rdata_valid[0], rdata[0]);
    end
    @(posedge clk); #1;
    rdata_ready = 1'b1;
    wait_beats(0, 4, base, ok);
    if (ok) begin
      total++;
      if (busy[0] !== 1'b1) begin
        bad++; $display("FAIL bp_busy_before_pop: busy=%b, required 1", busy[0]);
      end
      @(negedge clk); #1;
      total++;
      if (busy[0] !== 1'b0) begin
        bad++; $display("FAIL bp_busy_after_pop: busy=%b, required 0", busy[0]);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (qget(0, base + i) !== {(i == 3), 128'hA0 + 128'(i)}) begin
          bad++;
          $display("FAIL bp_beat%0d: got %h, required %h", i, qget(0, base + i), {(i == 3), 128'hA0 + 128'(i)});
        end
      end
      total++;
      if (rd_cnt[0] - cnt0 !== 4) begin
        bad++; $display("FAIL bp_reads: got %0d, required 4", rd_cnt[0] - cnt0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_write;
    int base;
    bit ok;
    rdata_ready = 1'b1;
    send_req(0, 1'b1, 8'd0);
    send_beats({4{128'h0 - 128'd1}}, {4{16'hFFFF}});
    send_req(0, 1'b1, 8'd0);
    send_beats({4{128'h0}}, {16'h0, 16'h0, 16'h0, 16'h0001});
    base = rq0.size();
    send_req(0, 1'b0, 8'd0);
    wait_beats(0, 4, base, ok);
    if (ok) begin
      total++;
      if (qget(0, base) !== {1'b0, {120{1'b1}}, 8'h00}) begin
        bad++; $display("FAIL partial_beat0: got %h, required %h", qget(0, base), {1'b0, {120{1'b1}}, 8'h00});
      end
      total++;
      if (qget(0, base + 1) !== {1'b0, {128{1'b1}}}) begin
        bad++; $display("FAIL partial_beat1: got %h, required %h", qget(0, base + 1), {1'b0, {128{1'b1}}});
      end
    end
    @(posedge clk); #1;
    wait_idle(0);
  endtask

  task automatic test_valid_pattern;
    logic [6:0] pat;
    int h;
    pat = 7'b1011001;
    h = 0;
    send_req(0, 1'b1, 8'd5);
    for (int i = 0; i < 7; i++) begin
      wdata_valid = pat[i]; wdata = 128'(i); wbe = '1;
      @(negedge clk); #1;
      total++;
      if (sram_req[0] !== pat[i] || sram_we[0] !== pat[i] || wdata_ready[0] !== 1'b1 ||
          (pat[i] && sram_addr[0] !== 10'(20 + h))) begin
        bad++;
        $display("FAIL pat_cycle%0d: req=%b we=%b wready=%b addr=%0d, required %b %b 1 %0d",
                 i, sram_req[0], sram_we[0], wdata_ready[0], sram_addr[0], pat[i], pat[i], 20 + h);
      end
      if (pat[i]) h++;
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready[0] !== 1'b1 || wdata_ready[0] !== 1'b0) begin
      bad++; $display("FAIL pat_idle: req_ready=%b wready=%b, required 1 0", req_ready[0], wdata_ready[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight;
    int cnt0, base;
    bit seen;
    rdata_ready = 1'b1;
    cnt0 = rd_cnt[1];
    base = rq1.size();
    send_req(1, 1'b0, 8'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rd_cnt[1] - cnt0 >= 2) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    total++;
    if (rd_cnt[1] - cnt0 !== 2) begin
      bad++; $display("FAIL rst_issues: got %0d reads, required 2", rd_cnt[1] - cnt0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready[1] !== 1'b1 || busy[1] !== 1'b0 || rdata_valid[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_release: req_ready=%b busy=%b rvalid=%b, required 1 0 0", req_ready[1], busy[1], rdata_valid[1]);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (rdata_valid[1] !== 1'b0 || busy[1] !== 1'b0) seen = 1;
    end
    total++;
    if (seen || rq1.size() != base) begin
      bad++; $display("FAIL rst_discard: stray activity=%0d beats=%0d, required 0 0", seen, rq1.size() - base);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int base;
    int acc[2];
    bit ok;
    rdata_ready = 1'b1;
    send_req(2, 1'b1, 8'd0);
    send_beats({128'hB3, 128'hB2, 128'hB1, 128'hB0}, {4{16'hFFFF}});
    send_req(2, 1'b1, 8'd1);
    send_beats({128'hC3, 128'hC2, 128'hC1, 128'hC0}, {4{16'hFFFF}});
    wait_idle(2);
    base = rq2.size();
    req_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ok = 0;
      req_valid = 3'b100; req_line = 8'(k);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        if (req_ready[2]) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      acc[k] = cyc;
      if (!ok) begin
        total++; bad++; $display("FAIL b2b_accept%0d: req_ready stayed 0, required 1", k);
      end
    end
    req_valid = '0;
    total++;
    if (acc[1] - acc[0] !== 5) begin
      bad++; $display("FAIL b2b_gap: accept spacing %0d cycles, required 5", acc[1] - acc[0]);
    end
    wait_beats(2, 8, base, ok);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        logic [127:0] exp_d;
        exp_d = (i < 4) ? 128'hB0 + 128'(i) : 128'hC0 + 128'(i - 4);
        total++;
        if (qget(2, base + i) !== {(i == 3 || i == 7), exp_d}) begin
          bad++;
          $display("FAIL b2b_beat%0d: got %h, required %h", i, qget(2, base + i), {(i == 3 || i == 7), exp_d});
        end
      end
    end
    @(posedge clk); #1;
    wait_idle(2);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = 1'b0; req_line = '0;
    wdata_valid = 1'b0; wdata = '0; wbe = '0; rdata_ready = 1'b0;
    test_reset;
    test_write_read;
    test_backpressure;
    test_partial_write;
    test_valid_pattern;
    test_reset_inflight;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
